// File: rtl/power_window_acc_if.sv
// Sample-in / mean-square-out bundle of the windowed power meter.
// peak_out exists only when PEAK_HOLD_EN is defined.
interface power_window_acc_if #(
   parameter int DW     = 16,
   parameter int LOG2_N = 12,
   parameter int OW     = 32
);
   logic                   in_valid;
   logic signed [DW-1:0]   x_in;
   logic                   ms_ready;
   logic                   ms_valid;
   logic [OW-1:0]          ms_out;
   logic                   overrun;
   logic [LOG2_N-1:0]      win_cnt;
`ifdef PEAK_HOLD_EN
   logic [DW-1:0]          peak_out;

   modport master (output in_valid, x_in, ms_ready,
                   input  ms_valid, ms_out, overrun, win_cnt, peak_out);
   modport slave  (input  in_valid, x_in, ms_ready,
                   output ms_valid, ms_out, overrun, win_cnt, peak_out);
`else
   modport master (output in_valid, x_in, ms_ready,
                   input  ms_valid, ms_out, overrun, win_cnt);
   modport slave  (input  in_valid, x_in, ms_ready,
                   output ms_valid, ms_out, overrun, win_cnt);
`endif
endinterface

// File: rtl/power_window_acc.sv
// Windowed mean-square power meter: squares samples, sums 2^LOG2_N of them and
// shifts down, handing the saturated mean over valid/ready. PEAK_HOLD_EN adds peak_out.
module power_window_acc #(
   parameter int DW     = 16,
   parameter int LOG2_N = 12,
   parameter int OW     = 32
) (
   input  logic               clk,
   input  logic               rst,
   power_window_acc_if.slave  bus
);
   localparam int MW    = 2 * DW;
   localparam int ACC_W = MW + LOG2_N;
   localparam logic [LOG2_N-1:0] LAST = '1;

   function automatic logic [OW-1:0] sat_ow(input logic [MW-1:0] m);
      logic [MW+OW-1:0] wide;
      logic [MW+OW-1:0] lim;
      wide = {{OW{1'b0}}, m};
      lim  = {{MW{1'b0}}, {OW{1'b1}}};
      if (wide > lim) return {OW{1'b1}};
      return OW'(m);
   endfunction

   // ---- stage 1: square the accepted sample ----
   logic signed [DW-1:0] x_s;
   logic signed [MW-1:0] prod_s;
   logic [MW-1:0]        sq_p1_d, sq_p1_q;
   logic                 vld_p1_d, vld_p1_q;

   always_comb begin
      x_s      = bus.x_in;
      prod_s   = MW'(x_s) * MW'(x_s);
      sq_p1_d  = unsigned'(prod_s);
      vld_p1_d = bus.in_valid;
   end

`ifdef PEAK_HOLD_EN
   function automatic logic [DW-1:0] sat_abs(input logic signed [DW-1:0] x);
      if (x == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
      if (x < 0) return unsigned'(-x);
      return unsigned'(x);
   endfunction

   logic [DW-1:0] abs_p1_d, abs_p1_q;
   always_comb abs_p1_d = sat_abs(x_s);
   always_ff @(posedge clk) abs_p1_q <= abs_p1_d;
`endif

   // Data-only register: its contents are ignored whenever vld_p1_q is low.
   always_ff @(posedge clk) sq_p1_q <= sq_p1_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_p1_q <= 1'b0;
      else     vld_p1_q <= vld_p1_d;
   end

   // ---- stage 2: accumulate, close window, hand off ----
   logic [ACC_W-1:0]  acc_d, acc_q, acc_sum;
   logic [MW-1:0]     mean;
   logic [LOG2_N-1:0] win_cnt_d, win_cnt_q;
   logic              ms_valid_d, ms_valid_q;
   logic [OW-1:0]     ms_out_d, ms_out_q;
   logic              overrun_d, overrun_q;
   logic              done;
`ifdef PEAK_HOLD_EN
   logic [DW-1:0]     peak_run_d, peak_run_q, peak_out_d, peak_out_q, peak_max;
`endif

   always_comb begin
      acc_sum    = acc_q + ACC_W'(sq_p1_q);
      mean       = acc_sum[ACC_W-1:LOG2_N];
      done       = vld_p1_q && (win_cnt_q == LAST);
      acc_d      = acc_q;
      win_cnt_d  = win_cnt_q;
      ms_out_d   = ms_out_q;
      overrun_d  = overrun_q;
      ms_valid_d = ms_valid_q && !bus.ms_ready;
      if (vld_p1_q) begin
         acc_d     = acc_sum;
         win_cnt_d = win_cnt_q + LOG2_N'(1);
      end
      if (done) begin
         acc_d      = '0;
         ms_out_d   = sat_ow(mean);
         ms_valid_d = 1'b1;
         // A still-pending result that is not taken this edge is lost.
         if (ms_valid_q && !bus.ms_ready) overrun_d = 1'b1;
      end
   end

`ifdef PEAK_HOLD_EN
   always_comb begin
      peak_max   = (abs_p1_q > peak_run_q) ? abs_p1_q : peak_run_q;
      peak_run_d = peak_run_q;
      peak_out_d = peak_out_q;
      if (vld_p1_q) peak_run_d = peak_max;
      if (done) begin
         peak_out_d = peak_max;
         peak_run_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         peak_run_q <= '0;
         peak_out_q <= '0;
      end else begin
         peak_run_q <= peak_run_d;
         peak_out_q <= peak_out_d;
      end
   end

   assign bus.peak_out = peak_out_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q      <= '0;
         win_cnt_q  <= '0;
         ms_valid_q <= 1'b0;
         ms_out_q   <= '0;
         overrun_q  <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         win_cnt_q  <= win_cnt_d;
         ms_valid_q <= ms_valid_d;
         ms_out_q   <= ms_out_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.ms_valid = ms_valid_q;
   assign bus.ms_out   = ms_out_q;
   assign bus.overrun  = overrun_q;
   assign bus.win_cnt  = win_cnt_q;

endmodule
